// File: rtl/sequence_output_collect_pkg.sv
// Shared types and constants for the sequence output collector.
package sequence_output_collect_pkg;

  // Frame assembly state: IDLE waits for a start-of-frame, FILL collects slots 1..N-1.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Offset applied by the biased sorter encoding: 2^(dw-1).
  // XOR-ing an element with this value flips its MSB and removes the bias.
  function automatic logic [31:0] debias_const(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/seq_hold_reg.sv
// Single-entry valid/ready holding stage for completed frames.
// Accepts a new frame whenever it is empty or is being drained in the same
// cycle, so back-to-back frames flow without a bubble. A frame offered while
// the stage is full and not draining is dropped and flagged on o_drop.
module seq_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_sorted,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_sorted,
  output logic         o_drop
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_sorted;
  logic         w_accept;

  assign w_accept = i_load && (!r_valid || i_ready);
  assign o_drop   = i_load && r_valid && !i_ready;

  // Load on accept, clear valid after a handshake, otherwise hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sorted <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_data   <= i_data;
      r_sorted <= i_sorted;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_sorted = r_sorted;

endmodule

// File: rtl/sequence_output_collect.sv
// Collects N serial elements from the sorter into one frame, removes the
// sign bias, tracks whether the frame arrived in non-decreasing order and
// hands it out through a valid/ready holding register.
module sequence_output_collect
  import sequence_output_collect_pkg::*;
#(
  parameter int DW     = 8,
  parameter int N      = 4,
  parameter int BIASED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_sorted,
  output logic            err_overflow,
  output logic            err_frame,
  input  logic            err_clr
);

  localparam int            IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] LP_BIAS = DW'(debias_const(DW));
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(N - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [N*DW-1:0]   r_frame;
  logic [DW-1:0]     r_prev;
  logic              r_sorted;
  logic              r_cpl;
  logic              r_err_frame;
  logic              r_err_overflow;

  logic [DW-1:0]     w_stored;
  logic              w_store;
  logic [IDX_W-1:0]  w_slot;
  logic              w_done;
  logic              w_drop;

  assign w_stored = (BIASED != 0) ? (in_data ^ LP_BIAS) : in_data;
  // A start-of-frame always lands in slot 0; continuation elements only count inside FILL.
  assign w_store  = in_valid && (in_sof || (r_state == FILL));
  assign w_slot   = in_sof ? '0 : r_idx;
  assign w_done   = in_valid && !in_sof && (r_state == FILL) && (r_idx == LP_LAST);

  // Element storage into the assembly buffer.
  // NOTE: the assembly buffer is pure datapath and is not reset; every slot is
  // rewritten before a frame completes, and r_cpl gates its use.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_frame[w_slot*DW +: DW] <= w_stored;
    end
  end

  // Frame FSM: index, sortedness tracking, completion strobe and sticky errors.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_prev         <= '0;
      r_sorted       <= 1'b0;
      r_cpl          <= 1'b0;
      r_err_frame    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_cpl <= w_done;

      if (in_valid && in_sof) begin
        r_state  <= FILL;
        r_idx    <= IDX_W'(1);
        r_prev   <= in_data;
        r_sorted <= 1'b1;
      end else if (in_valid && (r_state == FILL)) begin
        r_prev <= in_data;
        if (in_data < r_prev) begin
          r_sorted <= 1'b0;
        end
        if (r_idx == LP_LAST) begin
          r_state <= IDLE;
          r_idx   <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      if (err_clr) begin
        r_err_frame <= 1'b0;
      end else if (in_valid && in_sof && (r_state == FILL)) begin
        r_err_frame <= 1'b1;
      end

      if (err_clr) begin
        r_err_overflow <= 1'b0;
      end else if (w_drop) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  seq_hold_reg #(
    .W (N*DW)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_cpl),
    .i_data   (r_frame),
    .i_sorted (r_sorted),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_sorted (out_sorted),
    .o_drop   (w_drop)
  );

  assign err_frame    = r_err_frame;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_sequence_output_collect.sv
// Directed bench for sequence_output_collect with DW=8, N=4, BIASED=1.
module tb_sequence_output_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sorted;
  logic        err_overflow;
  logic        err_frame;
  logic        err_clr;

  int n_total = 0;
  int n_bad   = 0;

  // Each accepted frame: {sorted, data}.
  logic [32:0] q_out[$];

  sequence_output_collect #(.DW(8), .N(4), .BIASED(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sorted   (out_sorted),
    .err_overflow (err_overflow),
    .err_frame    (err_frame),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Record every output handshake using pre-edge values.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) q_out.push_back({out_sorted, out_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send(1'b1, a);
    send(1'b0, b);
    send(1'b0, c);
    send(1'b0, d);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    check("rst_valid",  out_valid,    1'b0);
    check("rst_data",   out_data,     32'h0);
    check("rst_sorted", out_sorted,   1'b0);
    check("rst_ovf",    err_overflow, 1'b0);
    check("rst_frm",    err_frame,    1'b0);
    rst = 1'b0;
    tick();

    // Basic frame, latency and single-cycle valid.
    q_out.delete();
    send_frame(8'h7E, 8'h80, 8'h81, 8'hFF);
    check("lat_early", out_valid, 1'b0);
    tick();
    check("lat_valid",  out_valid,  1'b1);
    check("f1_data",    out_data,   32'h7F0100FE);
    check("f1_sorted",  out_sorted, 1'b1);
    tick();
    check("f1_once", out_valid, 1'b0);
    check("f1_count", q_out.size(), 1);

    // Unsorted frame.
    send_frame(8'h90, 8'h85, 8'hA0, 8'hB0);
    tick();
    check("f2_valid",  out_valid,  1'b1);
    check("f2_data",   out_data,   32'h30200510);
    check("f2_sorted", out_sorted, 1'b0);
    tick();

    // Overflow with the consumer stalled.
    out_ready = 1'b0;
    q_out.delete();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    send_frame(8'h10, 8'h20, 8'h30, 8'h05);
    tick(); tick();
    check("ovf_valid",  out_valid,    1'b1);
    check("ovf_held",   out_data,     32'h84838281);
    check("ovf_sorted", out_sorted,   1'b1);
    check("ovf_flag",   err_overflow, 1'b1);
    check("ovf_nofrm",  err_frame,    1'b0);
    pulse_clr();
    check("ovf_clr", err_overflow, 1'b0);
    out_ready = 1'b1;
    tick(); tick();
    check("ovf_drain_n", q_out.size(), 1);
    check("ovf_drain_d", q_out[0], {1'b1, 32'h84838281});
    check("ovf_empty",   out_valid, 1'b0);

    // Aborted partial frame.
    q_out.delete();
    send(1'b1, 8'h11);
    send(1'b0, 8'h22);
    send_frame(8'h40, 8'h50, 8'h60, 8'h70);
    tick(); tick(); tick();
    check("frm_flag", err_frame, 1'b1);
    check("frm_n",    q_out.size(), 1);
    check("frm_d",    q_out[0], {1'b1, 32'hF0E0D0C0});
    pulse_clr();
    check("frm_clr", err_frame, 1'b0);

    // Reset mid-frame, stray element, then a full frame.
    q_out.delete();
    send(1'b1, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1'b0, 8'h55);
    send_frame(8'h7F, 8'h00, 8'h00, 8'h01);
    tick(); tick(); tick();
    check("rstm_n",   q_out.size(), 1);
    check("rstm_d",   q_out[0], {1'b0, 32'h818080FF});
    check("rstm_ovf", err_overflow, 1'b0);
    check("rstm_frm", err_frame,    1'b0);

    // Back-to-back frames with out_ready toggling every cycle.
    q_out.delete();
    out_ready = 1'b0;
    fork
      begin
        repeat (20) begin
          out_ready = ~out_ready;
          tick();
        end
      end
      begin
        send_frame(8'h00, 8'h01, 8'h02, 8'h03);
        send_frame(8'h10, 8'h0F, 8'h11, 8'h12);
        send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      end
    join
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("b2b_n",   q_out.size(), 3);
    check("b2b_d0",  q_out[0], {1'b1, 32'h83828180});
    check("b2b_d1",  q_out[1], {1'b0, 32'h92918F90});
    check("b2b_d2",  q_out[2], {1'b1, 32'h23222120});
    check("b2b_ovf", err_overflow, 1'b0);
    check("b2b_frm", err_frame,    1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
